// File: rtl/uart_pkg.sv
// Shared UART definitions: baud select codes, receive divisor table,
// receiver state encoding and the 3-sample majority vote.
package uart_pkg;

   localparam logic [1:0] BD_1200 = 2'b00;
   localparam logic [1:0] BD_2400 = 2'b01;
   localparam logic [1:0] BD_4800 = 2'b10;
   localparam logic [1:0] BD_9600 = 2'b11;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      START = 2'b01,
      DATA  = 2'b10,
      STOP  = 2'b11
   } rx_state_t;

   // Clocks per oversampling tick, rounded to nearest: round(clk/(16*baud)).
   function automatic int div_for(input logic [1:0] rate, input int clk_freq);
      int baud;
      case (rate)
         BD_1200: baud = 32'sd1200;
         BD_2400: baud = 32'sd2400;
         BD_4800: baud = 32'sd4800;
         BD_9600: baud = 32'sd9600;
         default: baud = 32'sd9600;
      endcase
      return (clk_freq + 32'sd8 * baud) / (32'sd16 * baud);
   endfunction

   function automatic logic majority3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_rx_tick_gen.sv
// 16x oversampling tick generator: the prescaler reloads at DIV-1 and pulses
// tick for one clock; clr restarts it so ticks line up with the start edge.
module uart_rx_tick_gen
   import uart_pkg::*;
#(
   parameter int CLK_FREQ = 50_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic [1:0] rate,
   output logic       tick
);

   localparam int PW = $clog2(div_for(BD_1200, CLK_FREQ));
   localparam logic [PW-1:0] LAST_1200 = PW'(div_for(BD_1200, CLK_FREQ) - 1);
   localparam logic [PW-1:0] LAST_2400 = PW'(div_for(BD_2400, CLK_FREQ) - 1);
   localparam logic [PW-1:0] LAST_4800 = PW'(div_for(BD_4800, CLK_FREQ) - 1);
   localparam logic [PW-1:0] LAST_9600 = PW'(div_for(BD_9600, CLK_FREQ) - 1);

   logic [PW-1:0] presc;
   logic [PW-1:0] last;

   // Divisor mux driven by the rate latched at the start of the frame.
   always_comb begin
      last = LAST_9600;
      case (rate)
         BD_1200: last = LAST_1200;
         BD_2400: last = LAST_2400;
         BD_4800: last = LAST_4800;
         BD_9600: last = LAST_9600;
         default: last = LAST_9600;
      endcase
   end

   // Prescaler; the >= compare keeps it inside range whatever the divisor.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         presc <= '0;
         tick  <= 1'b0;
      end else if (presc >= last) begin
         presc <= '0;
         tick  <= 1'b1;
      end else begin
         presc <= presc + 1'b1;
         tick  <= 1'b0;
      end
   end

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: two-flop synchronizer, 16x oversampled bit FSM with a
// majority vote on ticks 7..9, right-shifting data register, pulse outputs.
module uart_rx_core
   import uart_pkg::*;
#(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int OVERSAMPLE = 16,
   parameter int DATA_BITS  = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [1:0]           bd_rate,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 frame_err,
   output logic                 rx_busy
);

   localparam int TW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_BITS);
   localparam logic [TW-1:0] T_S0   = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] T_S1   = TW'(OVERSAMPLE / 2);
   localparam logic [TW-1:0] T_DEC  = TW'(OVERSAMPLE / 2 + 1);
   localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

   rx_state_t            state, state_nx;
   logic                 rx_meta, rx_s;
   logic [1:0]           rate_q, rate_nx;
   logic [TW-1:0]        tick_cnt, tick_cnt_nx;
   logic [BW-1:0]        bit_cnt, bit_cnt_nx;
   logic [1:0]           samp, samp_nx;
   logic [DATA_BITS-1:0] shreg, shreg_nx, rx_data_nx;
   logic                 armed, armed_nx, valid_nx, err_nx;
   logic                 clr, tick, maj, decide, bit_end;

   uart_rx_tick_gen #(.CLK_FREQ(CLK_FREQ)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .clr  (clr),
      .rate (rate_q),
      .tick (tick)
   );

   // Two-flop synchronizer; resets high so reset never looks like a start edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
      end
   end

   assign maj     = majority3(samp[0], samp[1], rx_s);
   assign decide  = tick && (tick_cnt == T_DEC);
   assign bit_end = tick && (tick_cnt == T_LAST);

   // Next-state, sampling, shifting and output-pulse logic.
   always_comb begin
      state_nx    = state;
      rate_nx     = rate_q;
      tick_cnt_nx = tick_cnt;
      bit_cnt_nx  = bit_cnt;
      samp_nx     = samp;
      shreg_nx    = shreg;
      rx_data_nx  = rx_data;
      armed_nx    = armed;
      valid_nx    = 1'b0;
      err_nx      = 1'b0;
      clr         = 1'b0;

      if ((state != IDLE) && tick) begin
         tick_cnt_nx = tick_cnt + 1'b1;
         if (tick_cnt == T_S0) begin
            samp_nx[0] = rx_s;
         end else if (tick_cnt == T_S1) begin
            samp_nx[1] = rx_s;
         end else begin
            samp_nx = samp;
         end
      end else begin
         tick_cnt_nx = tick_cnt;
      end

      case (state)
         IDLE: begin
            // After a break the line must return high before a new start counts.
            if (armed && !rx_s) begin
               state_nx    = START;
               clr         = 1'b1;
               tick_cnt_nx = '0;
               bit_cnt_nx  = '0;
               rate_nx     = bd_rate;
            end else if (rx_s) begin
               armed_nx = 1'b1;
            end else begin
               armed_nx = armed;
            end
         end
         START: begin
            if (decide && maj) begin
               state_nx = IDLE;
            end else if (bit_end) begin
               state_nx = DATA;
            end else begin
               state_nx = state;
            end
         end
         DATA: begin
            if (decide) begin
               shreg_nx = {maj, shreg[DATA_BITS-1:1]};
            end else if (bit_end) begin
               if (bit_cnt == B_LAST) begin
                  state_nx = STOP;
               end else begin
                  bit_cnt_nx = bit_cnt + 1'b1;
               end
            end else begin
               state_nx = state;
            end
         end
         STOP: begin
            if (decide) begin
               state_nx = IDLE;
               if (maj) begin
                  rx_data_nx = shreg;
                  valid_nx   = 1'b1;
               end else begin
                  err_nx   = 1'b1;
                  armed_nx = 1'b0;
               end
            end else begin
               state_nx = state;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Datapath and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         rate_q    <= BD_1200;
         tick_cnt  <= '0;
         bit_cnt   <= '0;
         samp      <= 2'b00;
         shreg     <= '0;
         armed     <= 1'b0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         rx_busy   <= 1'b0;
      end else begin
         rate_q    <= rate_nx;
         tick_cnt  <= tick_cnt_nx;
         bit_cnt   <= bit_cnt_nx;
         samp      <= samp_nx;
         shreg     <= shreg_nx;
         armed     <= armed_nx;
         rx_data   <= rx_data_nx;
         rx_valid  <= valid_nx;
         frame_err <= err_nx;
         rx_busy   <= (state_nx != IDLE);
      end
   end

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core; a reduced clock frequency keeps the
// frames short while the divisor rule and frame timing stay the same.
module tb_uart_rx_core;

   localparam int TB_CLK = 768_000;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] bd_rate = 2'b00;
   logic       rx = 1'b1;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;
   logic       rx_busy;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] model_data = 8'h00;

   logic [7:0] got_q[$];
   int         err_cnt = 0;
   int         busy_rises = 0;
   logic       prev_busy = 1'b0;

   uart_rx_core #(.CLK_FREQ(TB_CLK)) dut (
      .clk       (clk),
      .rst       (rst),
      .bd_rate   (bd_rate),
      .rx        (rx),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .frame_err (frame_err),
      .rx_busy   (rx_busy)
   );

   always #5 clk = ~clk;

   // Event monitor: records every received byte, error pulse and busy start.
   always @(negedge clk) begin
      if (rx_valid) got_q.push_back(rx_data);
      if (frame_err) err_cnt <= err_cnt + 1;
      if (rx_busy && !prev_busy) busy_rises <= busy_rises + 1;
      prev_busy <= rx_busy;
   end

   // Clocks per bit: 16 ticks of round(clk / (16 * baud)).
   function automatic int bit_clk(input logic [1:0] r);
      int baud;
      baud = 1200 << r;
      return 16 * ((TB_CLK + 8 * baud) / (16 * baud));
   endfunction

   function automatic logic [8:0] got_at(input int idx);
      if (idx < got_q.size()) return {1'b1, got_q[idx]};
      return 9'h000;
   endfunction

   task automatic drive_bits(input logic [9:0] f, input int n, input int bclk);
      for (int i = 0; i < n; i++) begin
         rx = f[i];
         repeat (bclk) @(negedge clk);
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop, input int bclk);
      drive_bits({stop, b, 1'b0}, 10, bclk);
   endtask

   task automatic idle(input int cycles);
      rx = 1'b1;
      repeat (cycles) @(negedge clk);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks += 4;
      if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", rx_data); end
      if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", rx_valid); end
      if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", frame_err); end
      if (rx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", rx_busy); end
      rst = 1'b0;
      model_data = 8'h00;
      idle(20);
   endtask

   task automatic test_basic;
      int bv, be;
      bv = got_q.size(); be = err_cnt;
      bd_rate = 2'b11;
      send_frame(8'hA5, 1'b1, bit_clk(2'b11));
      idle(bit_clk(2'b11));
      model_data = 8'hA5;
      checks += 4;
      if (got_q.size() - bv !== 1) begin errors++; $display("FAIL basic_count: got %0d expected 1", got_q.size() - bv); end
      if (got_at(bv) !== 9'h1A5) begin errors++; $display("FAIL basic_data: got %h expected 1a5", got_at(bv)); end
      if (err_cnt - be !== 0) begin errors++; $display("FAIL basic_err: got %0d expected 0", err_cnt - be); end
      if (rx_data !== model_data) begin errors++; $display("FAIL basic_hold: got %h expected %h", rx_data, model_data); end
   endtask

   task automatic test_back_to_back;
      int bv, be, bb;
      bv = got_q.size(); be = err_cnt; bb = busy_rises;
      bd_rate = 2'b00;
      send_frame(8'h00, 1'b1, bit_clk(2'b00));
      send_frame(8'hFF, 1'b1, bit_clk(2'b00));
      idle(bit_clk(2'b00));
      model_data = 8'hFF;
      checks += 5;
      if (got_q.size() - bv !== 2) begin errors++; $display("FAIL b2b_count: got %0d expected 2", got_q.size() - bv); end
      if (got_at(bv) !== 9'h100) begin errors++; $display("FAIL b2b_first: got %h expected 100", got_at(bv)); end
      if (got_at(bv + 1) !== 9'h1FF) begin errors++; $display("FAIL b2b_second: got %h expected 1ff", got_at(bv + 1)); end
      if (busy_rises - bb !== 2) begin errors++; $display("FAIL b2b_busy_gap: got %0d busy starts expected 2", busy_rises - bb); end
      if (err_cnt - be !== 0) begin errors++; $display("FAIL b2b_err: got %0d expected 0", err_cnt - be); end
   endtask

   task automatic test_glitch;
      int bv, be, bb;
      bv = got_q.size(); be = err_cnt; bb = busy_rises;
      bd_rate = 2'b11;
      rx = 1'b0;
      repeat (6 * bit_clk(2'b11) / 16) @(negedge clk);
      idle(2 * bit_clk(2'b11));
      checks += 4;
      if (got_q.size() - bv !== 0) begin errors++; $display("FAIL glitch_valid: got %0d expected 0", got_q.size() - bv); end
      if (err_cnt - be !== 0) begin errors++; $display("FAIL glitch_err: got %0d expected 0", err_cnt - be); end
      if (busy_rises - bb !== 1) begin errors++; $display("FAIL glitch_start: got %0d expected 1", busy_rises - bb); end
      if (rx_busy !== 1'b0) begin errors++; $display("FAIL glitch_idle: got %b expected 0", rx_busy); end
   endtask

   task automatic test_break;
      int bv, be, bb, bclk;
      bclk = bit_clk(2'b11);
      bv = got_q.size(); be = err_cnt; bb = busy_rises;
      bd_rate = 2'b11;
      send_frame(8'h3C, 1'b0, bclk);
      rx = 1'b0;
      repeat (20 * bclk) @(negedge clk);
      checks += 4;
      if (err_cnt - be !== 1) begin errors++; $display("FAIL break_err: got %0d expected 1", err_cnt - be); end
      if (got_q.size() - bv !== 0) begin errors++; $display("FAIL break_valid: got %0d expected 0", got_q.size() - bv); end
      if (rx_data !== model_data) begin errors++; $display("FAIL break_hold: got %h expected %h", rx_data, model_data); end
      if (busy_rises - bb !== 1) begin errors++; $display("FAIL break_rearm: got %0d expected 1", busy_rises - bb); end
      idle(2 * bclk);
      send_frame(8'h3C, 1'b1, bclk);
      idle(bclk);
      model_data = 8'h3C;
      checks += 1;
      if (got_at(bv) !== 9'h13C) begin errors++; $display("FAIL break_recover: got %h expected 13c", got_at(bv)); end
   endtask

   task automatic test_reset_mid;
      int bv, be, bclk;
      logic [9:0] f;
      bclk = bit_clk(2'b01);
      bv = got_q.size(); be = err_cnt;
      bd_rate = 2'b01;
      f = {1'b1, 8'hC3, 1'b0};
      drive_bits(f, 5, bclk);
      rx = f[5];
      repeat (bclk / 2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      model_data = 8'h00;
      checks += 3;
      if (rx_data !== 8'h00) begin errors++; $display("FAIL rstmid_data: got %h expected 00", rx_data); end
      if (rx_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", rx_busy); end
      if ((rx_valid | frame_err) !== 1'b0) begin errors++; $display("FAIL rstmid_pulse: got %b expected 0", rx_valid | frame_err); end
      rst = 1'b0;
      idle(2 * bclk);
      send_frame(8'h5A, 1'b1, bclk);
      idle(bclk);
      model_data = 8'h5A;
      checks += 3;
      if (got_q.size() - bv !== 1) begin errors++; $display("FAIL rstmid_count: got %0d expected 1", got_q.size() - bv); end
      if (got_at(bv) !== 9'h15A) begin errors++; $display("FAIL rstmid_next: got %h expected 15a", got_at(bv)); end
      if (err_cnt - be !== 0) begin errors++; $display("FAIL rstmid_err: got %0d expected 0", err_cnt - be); end
   endtask

   task automatic test_rate_change;
      int bv, be;
      logic [7:0] b2;
      bv = got_q.size(); be = err_cnt;
      b2 = 8'($urandom);
      bd_rate = 2'b10;
      fork
         send_frame(8'h81, 1'b1, bit_clk(2'b10));
         begin
            repeat (4 * bit_clk(2'b10)) @(negedge clk);
            bd_rate = 2'b11;
         end
      join
      idle(bit_clk(2'b11));
      send_frame(b2, 1'b1, bit_clk(2'b11));
      idle(bit_clk(2'b11));
      model_data = b2;
      checks += 4;
      if (got_q.size() - bv !== 2) begin errors++; $display("FAIL rate_count: got %0d expected 2", got_q.size() - bv); end
      if (got_at(bv) !== 9'h181) begin errors++; $display("FAIL rate_old: got %h expected 181", got_at(bv)); end
      if (got_at(bv + 1) !== {1'b1, b2}) begin errors++; $display("FAIL rate_new: got %h expected %h", got_at(bv + 1), {1'b1, b2}); end
      if (err_cnt - be !== 0) begin errors++; $display("FAIL rate_err: got %0d expected 0", err_cnt - be); end
   endtask

   task automatic test_random;
      int bv, be, exp_err, bclk;
      logic [7:0] exp_q[$];
      logic [7:0] b;
      logic [1:0] r;
      logic stop;
      bv = got_q.size(); be = err_cnt; exp_err = 0;
      for (int n = 0; n < 12; n++) begin
         r = 2'($urandom_range(1, 3));
         b = 8'($urandom);
         stop = ($urandom_range(0, 3) != 0);
         bclk = bit_clk(r);
         bd_rate = r;
         send_frame(b, stop, bclk);
         idle(bclk * $urandom_range(1, 2));
         if (stop) begin
            exp_q.push_back(b);
            model_data = b;
         end else begin
            exp_err++;
         end
         checks += 3;
         if (got_q.size() - bv !== exp_q.size()) begin errors++; $display("FAIL rand_count[%0d]: got %0d expected %0d", n, got_q.size() - bv, exp_q.size()); end
         if (err_cnt - be !== exp_err) begin errors++; $display("FAIL rand_err[%0d]: got %0d expected %0d", n, err_cnt - be, exp_err); end
         if (rx_data !== model_data) begin errors++; $display("FAIL rand_hold[%0d]: got %h expected %h", n, rx_data, model_data); end
      end
      foreach (exp_q[i]) begin
         checks++;
         if (got_at(bv + i) !== {1'b1, exp_q[i]}) begin errors++; $display("FAIL rand_data[%0d]: got %h expected %h", i, got_at(bv + i), {1'b1, exp_q[i]}); end
      end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_back_to_back;
      test_glitch;
      test_break;
      test_reset_mid;
      test_rate_change;
      test_random;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
